// File: rtl/queue_occupancy_counter_if.sv
// Sensor inputs and occupancy/status outputs of the queue occupancy counter.
// The master modport is the counter itself, which writes pcount; the slave modport is a consumer of pcount.
interface queue_occupancy_counter_if #(
   parameter int n = 3
);
   logic         b_sensor;
   logic         f_sensor;
   logic [n-1:0] pcount;
   logic         full_flag;
   logic         empty_flag;
   logic         entry_evt;
   logic         exit_evt;
   logic         err_flag;

   modport master (
      input  b_sensor, f_sensor,
      output pcount, full_flag, empty_flag, entry_evt, exit_evt, err_flag
   );

   modport slave (
      output b_sensor, f_sensor,
      input  pcount, full_flag, empty_flag, entry_evt, exit_evt, err_flag
   );
endinterface

// File: rtl/queue_occupancy_counter.sv
// Synchronizes and debounces the entry/exit photocells, detects pass-throughs and keeps a saturating occupancy count.
// Optional macro QUEUE_ERR_EN builds the sticky dropped-event flag; without it err_flag is tied to 0.
module queue_occupancy_counter #(
   parameter int n         = 3,
   parameter int DB_CYCLES = 4,
   parameter int DB_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   queue_occupancy_counter_if.master    bus
);
   localparam logic [n-1:0]    MAXP    = {n{1'b1}};
   localparam logic [n-1:0]    ZERO_P  = {n{1'b0}};
   localparam logic [n-1:0]    ONE_P   = {{(n-1){1'b0}}, 1'b1};
   localparam logic [DB_W-1:0] ZERO_C  = {DB_W{1'b0}};
   localparam logic [DB_W-1:0] ONE_C   = {{(DB_W-1){1'b0}}, 1'b1};
   localparam logic [DB_W-1:0] CNT_TOP = DB_W'(DB_CYCLES - 1);

   // Index 0 is the back (entry) sensor, index 1 the front (exit) sensor.
   logic [1:0]            s1_q, s2_q;
   logic [1:0]            filt_q, filt_d;
   logic [1:0]            filt_p_q;
   logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
   logic [1:0]            fall_s;
   logic [n-1:0]          pcount_q, pcount_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  entry_q, exit_q;

   // Debounce: a filtered level follows s2 only after DB_CYCLES consecutive differing samples.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = ZERO_C;
         end else if (cnt_q[i] == CNT_TOP) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = ZERO_C;
         end else begin
            cnt_d[i] = cnt_q[i] + ONE_C;
         end
      end
   end

   // A pass-through is the beam being restored, i.e. a falling edge of the filtered level.
   assign fall_s = filt_p_q & ~filt_q;

   // Saturating count update; flags follow the next count so they are registered alongside it.
   always_comb begin
      pcount_d = pcount_q;
      case (fall_s)
         2'b01: begin
            if (!full_q) begin
               pcount_d = pcount_q + ONE_P;
            end else begin
               pcount_d = pcount_q;
            end
         end
         2'b10: begin
            if (!empty_q) begin
               pcount_d = pcount_q - ONE_P;
            end else begin
               pcount_d = pcount_q;
            end
         end
         2'b11: begin
            if (empty_q) begin
               pcount_d = ONE_P;
            end else begin
               pcount_d = pcount_q;
            end
         end
         default: pcount_d = pcount_q;
      endcase
      full_d  = (pcount_d == MAXP);
      empty_d = (pcount_d == ZERO_P);
   end

   // Synchronizers, debounce state, count and event pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q     <= 2'b00;
         s2_q     <= 2'b00;
         filt_q   <= 2'b00;
         filt_p_q <= 2'b00;
         cnt_q    <= {(2*DB_W){1'b0}};
         pcount_q <= ZERO_P;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         entry_q  <= 1'b0;
         exit_q   <= 1'b0;
      end else begin
         s1_q     <= {bus.f_sensor, bus.b_sensor};
         s2_q     <= s1_q;
         filt_q   <= filt_d;
         filt_p_q <= filt_q;
         cnt_q    <= cnt_d;
         pcount_q <= pcount_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         entry_q  <= fall_s[0];
         exit_q   <= fall_s[1];
      end
   end

`ifdef QUEUE_ERR_EN
   logic drop_s;
   logic err_q, err_d;

   // Dropped: entry alone while full, or any exit while empty.
   always_comb begin
      drop_s = (fall_s[0] & ~fall_s[1] & full_q) | (fall_s[1] & empty_q);
      err_d  = err_q | drop_s;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err_flag = err_q;
`else
   assign bus.err_flag = 1'b0;
`endif

   assign bus.pcount     = pcount_q;
   assign bus.full_flag  = full_q;
   assign bus.empty_flag = empty_q;
   assign bus.entry_evt  = entry_q;
   assign bus.exit_evt   = exit_q;
endmodule

// File: doc/queue_occupancy_counter.md
Name: queue_occupancy_counter

Overview:
- Front end of the queue-management datapath. Watches the two photocell sensors: back sensor = entry, front sensor = exit.
- Synchronizes and debounces each sensor and detects completed pass-throughs.
- Maintains the saturating person count `pcount` that the waiting-time lookup consumes, plus registered full/empty status.
- Writer side of the `pcount` interface; `pcount` width and encoding match the lookup's address field exactly.

Parameters:
- `n`, default 3: width of `pcount`; max occupancy `MAXP = 2^n - 1` (7 at default).
- `DB_CYCLES`, default 4: consecutive stable synchronized samples needed before a filtered sensor level changes; legal range 1 to 255.
- `DB_W`, default 8: width of each debounce counter; must hold `DB_CYCLES - 1`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `b_sensor`, input, 1: back/entry photocell, asynchronous; 1 = beam broken.
- `f_sensor`, input, 1: front/exit photocell, asynchronous; 1 = beam broken.
- `pcount`, output, n: current occupancy, 0 to MAXP, registered.
- `full_flag`, output, 1: registered; 1 iff `pcount == MAXP`.
- `empty_flag`, output, 1: registered; 1 iff `pcount == 0`.
- `entry_evt`, output, 1: one-cycle pulse on each detected entry pass-through.
- `exit_evt`, output, 1: one-cycle pulse on each detected exit pass-through.
- `err_flag`, output, 1: sticky dropped-event flag (see Optional Feature).

Behaviour:
- Reset (`rst_n == 0` at an edge):
  - both 2-flop synchronizers = 0, filtered levels = 0, debounce counters = 0;
  - `pcount = 0`, `empty_flag = 1`, `full_flag = 0`;
  - `entry_evt = 0`, `exit_evt = 0`, `err_flag = 0`.
  - Reset mid-debounce or mid-pass-through discards all pending state. No event is generated from the level held across reset.
- Synchronizer: per sensor, `s1 <= sensor`, `s2 <= s1`.
- Debounce, per sensor, each edge:
  - if `s2 == filt`: `cnt <= 0`;
  - else if `cnt == DB_CYCLES - 1`: `filt <= s2`, `cnt <= 0`;
  - else: `cnt <= cnt + 1`.
  - Any bounce back to `filt` restarts the count.
- Pass-through: a falling edge of `filt` (beam broken, then restored). The rising edge of `filt` alone generates nothing.
- Latency: a sensor change that is stable before edge 1 gives:
  - `filt` changes at edge `DB_CYCLES + 2`;
  - the evt pulse and `pcount` update at edge `DB_CYCLES + 3` (edge 7 at default).
- Count update, at the same edge as the evt pulses; E = entry detected, X = exit detected:
  - E only, not full: `pcount + 1`. E only, full: unchanged, entry dropped.
  - X only, not empty: `pcount - 1`. X only, empty: unchanged, exit dropped.
  - E and X, not empty: unchanged (net zero, including at full).
  - E and X, empty: `pcount = 1`, exit dropped.
- `pcount` never wraps.
- `entry_evt` / `exit_evt` pulse on detection even when the event is dropped.
- `full_flag` / `empty_flag` are computed from the next `pcount` value and registered with it, so they never disagree with `pcount` in any cycle.

Optional Feature:
- Macro: `QUEUE_ERR_EN`.
- Defined: `err_flag` is set at the edge on which any event is dropped, i.e.:
  - entry at full with no exit;
  - exit at empty, alone or simultaneous with an entry.
  - Once set, it holds until reset.
- Undefined: no error logic is built; the `err_flag` port remains and is tied to 0.

Test Plan (`DB_CYCLES = 4`, `n = 3`):
1. Reset, then pulse `b_sensor` high for 10 cycles and low again -> one `entry_evt` exactly 7 edges after the release; `pcount` 0->1; `empty_flag` 1->0.
2. Toggle `b_sensor` every 2 cycles for 20 cycles, then hold low -> no `entry_evt`; `pcount` unchanged.
3. Perform 9 clean entries -> `pcount` saturates at 7; `full_flag = 1` from the 7th entry. Then one exit -> `pcount = 6`, `full_flag = 0`. With the macro defined, `err_flag = 1` after the 8th entry.
4. From empty, one exit -> `exit_evt` pulses, `pcount` stays 0. With the macro defined, `err_flag = 1`; undefined, `err_flag = 0`.
5. Release both sensors on the same cycle:
   - at `pcount = 3` -> both evts pulse, `pcount` stays 3;
   - at `pcount = 0` -> `pcount = 1`;
   - at `pcount = 7` -> `pcount` stays 7, `err_flag` stays 0.
6. Assert `rst_n = 0` while `b_sensor` is mid-debounce with `pcount = 5` -> all outputs return to reset values. Releasing the sensor afterward produces no `entry_evt`, because `filt` is still 0.
